// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state type and counter-width helper for seq_mul.
package seq_mul_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: request/result bundle for seq_mul; sgn exists only with SEQ_MUL_SIGNED_EN.
interface seq_mul_if #(parameter int WIDTH = 8);
    localparam int OW = 2 * WIDTH;
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SEQ_MUL_SIGNED_EN
    logic sgn;
`endif
    logic busy;
    logic fin;
    logic [OW-1:0] o;
`ifdef SEQ_MUL_SIGNED_EN
    modport master(output start, a, b, sgn, input busy, fin, o);
    modport slave(input start, a, b, sgn, output busy, fin, o);
`else
    modport master(output start, a, b, input busy, fin, o);
    modport slave(input start, a, b, output busy, fin, o);
`endif
endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: IDLE/RUN/DONE sequencer and MSB-first step counter for seq_mul.
module seq_mul_ctrl import seq_mul_pkg::*; #(
    parameter int WIDTH = 8,
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          fin,
    output logic          load,
    output logic          step,
    output logic [CW-1:0] idx
);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= nxt;
            cnt <= load ? CW'(WIDTH - 1) : step ? cnt - CW'(1) : cnt;
        end
    end
    // IDLE and DONE both accept a new request, giving back-to-back operation
    always_comb begin
        nxt = state;
        load = 1'b0;
        case (state)
            RUN: nxt = (cnt == '0) ? DONE : RUN;
            default: begin
                load = start;
                nxt = start ? RUN : IDLE;
            end
        endcase
    end
    assign busy = (state == RUN);
    assign step = busy;
    assign fin = (state == DONE);
    assign idx = cnt;
endmodule

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add multiplier, one multiplier bit per cycle, MSB first.
// Define SEQ_MUL_SIGNED_EN to add the sgn input and two's-complement operands.
module seq_mul import seq_mul_pkg::*; #(
    parameter int WIDTH = 8,
    localparam int OW = 2 * WIDTH,
    localparam int CW = cnt_w(WIDTH)
) (
    input logic ck,
    input logic rst,
    seq_mul_if.slave bus
);
    logic load, step;
    logic [CW-1:0] idx;
    logic [WIDTH-1:0] a_lat, b_lat;
    logic [OW-1:0] o_q, ext, addend, o_nxt;
    seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .ck(ck),
        .rst(rst),
        .start(bus.start),
        .busy(bus.busy),
        .fin(bus.fin),
        .load(load),
        .step(step),
        .idx(idx)
    );
`ifdef SEQ_MUL_SIGNED_EN
    logic sgn_lat;
    always_ff @(posedge ck or posedge rst) begin
        if (rst) sgn_lat <= 1'b0;
        else if (load) sgn_lat <= bus.sgn;
    end
    // the multiplier's sign bit carries weight -2^(WIDTH-1), hence the subtract
    assign ext = {{WIDTH{sgn_lat & a_lat[WIDTH-1]}}, a_lat};
    assign addend = b_lat[idx] ? ext : '0;
    assign o_nxt = (sgn_lat && idx == CW'(WIDTH - 1)) ? (o_q << 1) - addend : (o_q << 1) + addend;
`else
    assign ext = {{WIDTH{1'b0}}, a_lat};
    assign addend = b_lat[idx] ? ext : '0;
    assign o_nxt = (o_q << 1) + addend;
`endif
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            a_lat <= '0;
            b_lat <= '0;
            o_q <= '0;
        end else if (load) begin
            a_lat <= bus.a;
            b_lat <= bus.b;
            o_q <= '0;
        end else if (step) begin
            o_q <= o_nxt;
        end
    end
    assign bus.o = o_q;
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: randomized self-checking bench for seq_mul at WIDTH=8 and WIDTH=16.
module tb_seq_mul;
    logic ck = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] res;
    int lat, busy_n, fins;
    logic s;
    always #5 ck = ~ck;
    seq_mul_if #(.WIDTH(8)) b8();
    seq_mul_if #(.WIDTH(16)) b16();
    seq_mul #(.WIDTH(8)) u8(.ck(ck), .rst(rst), .bus(b8));
    seq_mul #(.WIDTH(16)) u16(.ck(ck), .rst(rst), .bus(b16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge ck);
        #1;
    endtask

    // product as plain integers: operands masked to w bits, optionally read as two's complement
    function automatic logic [63:0] model(input int w, input logic [31:0] x, input logic [31:0] y, input logic sg);
        longint ax, bx;
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        ax = longint'(x & m);
        bx = longint'(y & m);
        if (sg && x[w-1]) ax -= longint'(1) << w;
        if (sg && y[w-1]) bx -= longint'(1) << w;
        return 64'(ax * bx) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic accept(input int w, input logic [31:0] x, input logic [31:0] y, input logic sg);
        if (w == 16) begin
            b16.start = 1'b1;
            b16.a = x[15:0];
            b16.b = y[15:0];
`ifdef SEQ_MUL_SIGNED_EN
            b16.sgn = sg;
`endif
        end else begin
            b8.start = 1'b1;
            b8.a = x[7:0];
            b8.b = y[7:0];
`ifdef SEQ_MUL_SIGNED_EN
            b8.sgn = sg;
`endif
        end
        cyc;
        b8.start = 1'b0;
        b16.start = 1'b0;
        b8.a = 8'($urandom);
        b8.b = 8'($urandom);
        b16.a = 16'($urandom);
        b16.b = 16'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
        b8.sgn = 1'($urandom);
        b16.sgn = 1'($urandom);
`endif
    endtask

    task automatic wait_fin(input int w, output logic [63:0] r, output int l, output int bn);
        l = 0;
        bn = 0;
        while (!(w == 16 ? b16.fin : b8.fin) && l < 40) begin
            bn += int'(w == 16 ? b16.busy : b8.busy);
            cyc;
            l++;
        end
        if (l >= 40) check("fin_timeout", 64'(l), 64'(w));
        r = (w == 16) ? 64'(b16.o) : 64'(b8.o);
    endtask

    task automatic op(input int w, input logic [31:0] x, input logic [31:0] y, input logic sg, input string tag);
        logic [63:0] r;
        int l, bn;
        accept(w, x, y, sg);
        wait_fin(w, r, l, bn);
        check(tag, r, model(w, x, y, sg));
        check({tag, "_lat"}, 64'(l), 64'(w));
        check({tag, "_busy_cycles"}, 64'(bn), 64'(w));
        check({tag, "_busy_at_fin"}, 64'(w == 16 ? b16.busy : b8.busy), 64'd0);
    endtask

    initial begin
        b8.start = 1'b0; b8.a = '0; b8.b = '0;
        b16.start = 1'b0; b16.a = '0; b16.b = '0;
`ifdef SEQ_MUL_SIGNED_EN
        b8.sgn = 1'b0;
        b16.sgn = 1'b0;
`endif
        #2;
        check("rst_busy", 64'(b8.busy), 64'd0);
        check("rst_fin", 64'(b8.fin), 64'd0);
        check("rst_o", 64'(b8.o), 64'd0);
        check("rst_o16", 64'(b16.o), 64'd0);
        cyc;
        rst = 1'b0;
        op(8, 255, 255, 1'b0, "ff_ff");
        check("ff_ff_lit", 64'(b8.o), 64'hFE01);
        cyc;
        check("done_one_cycle", 64'(b8.fin), 64'd0);
        check("o_hold", 64'(b8.o), 64'hFE01);
        op(8, 0, 173, 1'b0, "zero_a");
        check("zero_a_lit", 64'(b8.o), 64'd0);
        op(8, 173, 0, 1'b0, "zero_b");
        check("zero_b_lit", 64'(b8.o), 64'd0);
        op(8, 1, 1, 1'b0, "one_one");
        check("one_one_lit", 64'(b8.o), 64'd1);
        cyc;
        // start during RUN cycle 3 must be ignored
        accept(8, 3, 5, 1'b0);
        cyc;
        cyc;
        b8.start = 1'b1; b8.a = 8'd7; b8.b = 8'd7;
        cyc;
        b8.start = 1'b0;
        wait_fin(8, res, lat, busy_n);
        check("ign_o", res, 64'd15);
        check("ign_lat", 64'(lat + 3), 64'd8);
        // back-to-back from DONE
        accept(8, 7, 7, 1'b0);
        check("b2b_fin_drop", 64'(b8.fin), 64'd0);
        check("b2b_busy", 64'(b8.busy), 64'd1);
        wait_fin(8, res, lat, busy_n);
        check("b2b_o", res, 64'd49);
        check("b2b_lat", 64'(lat), 64'd8);
        cyc;
        check("b2b_no_extra_fin", 64'(b8.fin), 64'd0);
        // reset in RUN cycle 4
        accept(8, 200, 100, 1'b0);
        cyc;
        cyc;
        cyc;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(b8.busy), 64'd0);
        check("arst_fin", 64'(b8.fin), 64'd0);
        check("arst_o", 64'(b8.o), 64'd0);
        cyc;
        rst = 1'b0;
        fins = 0;
        repeat (12) begin
            cyc;
            fins += int'(b8.fin);
        end
        check("arst_no_fin", 64'(fins), 64'd0);
        op(8, 12, 12, 1'b0, "post_rst");
        check("post_rst_lit", 64'(b8.o), 64'd144);
`ifdef SEQ_MUL_SIGNED_EN
        op(8, 32'h80, 32'h80, 1'b1, "s_80_80");
        check("s_80_80_lit", 64'(b8.o), 64'h4000);
        op(8, 32'hFF, 32'h01, 1'b1, "s_ff_01");
        check("s_ff_01_lit", 64'(b8.o), 64'hFFFF);
        op(8, 32'hFF, 32'h01, 1'b0, "u_ff_01");
        check("u_ff_01_lit", 64'(b8.o), 64'h00FF);
`endif
        repeat (30) begin
            s = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
            s = 1'($urandom_range(1));
`endif
            op(8, $urandom, $urandom, s, "rnd8");
        end
        op(16, 32'hFFFF, 32'hFFFF, 1'b0, "w16_max");
        check("w16_max_lit", 64'(b16.o), 64'hFFFE0001);
        repeat (10) begin
            s = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
            s = 1'($urandom_range(1));
`endif
            op(16, $urandom, $urandom, s, "rnd16");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
